// File: rtl/hr_measure_ctrl.sv
// Heart-rate measurement sequencer: settle on start-up peaks, count peaks over a window, scale to BPM.
// Build option HR_AUTO_RESTART_EN: after each result, open the next window directly without a new start.
module hr_measure_ctrl #(
    parameter int WINDOW_CYCLES  = 400000000,
    parameter int BPM_MULT       = 6,
    parameter int DISCARD_PEAKS  = 3,
    parameter int TIMEOUT_CYCLES = 80000000,
    parameter int CNT_W          = 29
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        found_peak,
    output logic [11:0] heart_rate,
    output logic        rate_valid,
    output logic        busy,
    output logic        no_signal,
    output logic [7:0]  peak_count,
    output logic [2:0]  state
);
    // state   | meaning
    // IDLE    | waiting for start
    // SETTLE  | discarding start-up peaks
    // WINDOW  | counting peaks over the measurement window
    // COMPUTE | result published, rate_valid high for this one cycle
    // FAULT   | no peak seen within the timeout; waits for start
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_WINDOW  = 3'd2,
        S_COMPUTE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       DISC_LAST = 8'((DISCARD_PEAKS > 0) ? DISCARD_PEAKS - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic             r_found_peak_q;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [7:0]       r_discard_cnt;
    logic [7:0]       r_peak_count;
    logic [7:0]       w_peak_count_nxt;
    logic [11:0]      r_heart_rate;
    logic [19:0]      w_product;
    logic             w_peak_evt;
    logic             w_timeout;
    logic             w_win_last;
    logic             w_start_meas;
    logic             w_clear_count;

    assign w_peak_evt = found_peak & ~r_found_peak_q;
    assign w_timeout  = ((r_state == S_SETTLE) || (r_state == S_WINDOW)) && (r_tmo_cnt == TMO_LAST);
    assign w_win_last = (r_state == S_WINDOW) && (r_cycle_cnt == WIN_LAST);

    always_comb begin
        w_next       = r_state;
        w_start_meas = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_FAULT: begin
                    if (start) begin
                        w_start_meas = 1'b1;
                        w_next       = (DISCARD_PEAKS == 0) ? S_WINDOW : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_timeout)
                        w_next = S_FAULT;
                    else if (w_peak_evt && (r_discard_cnt == DISC_LAST))
                        w_next = S_WINDOW;
                end
                S_WINDOW: begin
                    if (w_timeout)
                        w_next = S_FAULT;
                    else if (w_win_last)
                        w_next = S_COMPUTE;
                end
                S_COMPUTE: begin
`ifdef HR_AUTO_RESTART_EN
                    w_next = S_WINDOW;
`else
                    w_next = S_IDLE;
`endif
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_clear_count = w_start_meas || ((r_state == S_COMPUTE) && (w_next == S_WINDOW));

    // Peaks only count while the window survives this cycle (abort and timeout take priority).
    always_comb begin
        w_peak_count_nxt = r_peak_count;
        if (w_clear_count)
            w_peak_count_nxt = '0;
        else if ((r_state == S_WINDOW) && w_peak_evt && !abort && !w_timeout && (r_peak_count != 8'hFF))
            w_peak_count_nxt = r_peak_count + 8'd1;
    end

    assign w_product = 20'(w_peak_count_nxt) * 20'(BPM_MULT);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_found_peak_q <= 1'b0;
            r_cycle_cnt    <= '0;
            r_tmo_cnt      <= '0;
            r_discard_cnt  <= '0;
            r_peak_count   <= '0;
            r_heart_rate   <= '0;
        end else begin
            r_found_peak_q <= found_peak;
            r_peak_count   <= w_peak_count_nxt;

            if ((r_state == S_WINDOW) && (w_next == S_WINDOW))
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            else
                r_cycle_cnt <= '0;

            // Timeout restarts on state entry and on every peak event.
            if (((w_next == S_SETTLE) || (w_next == S_WINDOW)) && (w_next == r_state) && !w_peak_evt)
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            else
                r_tmo_cnt <= '0;

            if (w_next != S_SETTLE)
                r_discard_cnt <= '0;
            else if ((r_state == S_SETTLE) && w_peak_evt)
                r_discard_cnt <= r_discard_cnt + 8'd1;

            if ((r_state == S_WINDOW) && (w_next == S_COMPUTE))
                r_heart_rate <= (|w_product[19:12]) ? 12'hFFF : w_product[11:0];
        end
    end

    assign heart_rate = r_heart_rate;
    assign rate_valid = (r_state == S_COMPUTE);
    assign busy       = (r_state == S_SETTLE) || (r_state == S_WINDOW) || (r_state == S_COMPUTE);
    assign no_signal  = (r_state == S_FAULT);
    assign peak_count = r_peak_count;
    assign state      = r_state;
endmodule
